// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and defaults for the sequential restoring divider
package div_pkg;

  localparam int WX_DEF    = 16;
  localparam int WY_DEF    = 8;
  localparam int CNT_W_DEF = $clog2(WX_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step
  import div_pkg::*;
#(
  parameter int WY = WY_DEF
) (
  input  logic [WY:0]   rem_i,
  input  logic          bit_i,
  input  logic [WY-1:0] divisor_i,
  output logic [WY:0]   rem_next_o,
  output logic          qbit_o
);

  logic [WY:0] shifted;
  logic [WY:0] dvs_ext;

  assign shifted = {rem_i[WY-1:0], bit_i};
  assign dvs_ext = {1'b0, divisor_i};

  // Shift in the next dividend bit, subtract the divisor when it fits.
  always_comb begin
    rem_next_o = shifted;
    qbit_o     = 1'b0;
    if (shifted >= dvs_ext) begin
      rem_next_o = shifted - dvs_ext;
      qbit_o     = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider, one quotient bit per clock
module seq_divider
  import div_pkg::*;
#(
  parameter int WX = WX_DEF,
  parameter int WY = WY_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [WX-1:0] X,
  input  logic [WY-1:0] Y,
  output logic          busy,
  output logic          done,
  output logic          div0,
  output logic [WX-1:0] Q,
  output logic [WY-1:0] R
);

  localparam int CW = (WX > 1) ? $clog2(WX) : 1;

  div_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [WX-1:0] shift_q;
  logic [WX-1:0] quo_q;
  logic [WY:0]   rem_q;
  logic [WY-1:0] dvs_q;
  logic          busy_q;
  logic          done_q;
  logic          div0_q;
  logic [WX-1:0] q_q;
  logic [WY-1:0] r_q;

  logic [WY:0]   rem_d;
  logic          qbit;
  logic [WX-1:0] quo_d;

  div_step #(.WY(WY)) u_step (
    .rem_i      (rem_q),
    .bit_i      (shift_q[WX-1]),
    .divisor_i  (dvs_q),
    .rem_next_o (rem_d),
    .qbit_o     (qbit)
  );

  assign quo_d = {quo_q[WX-2:0], qbit};

  // Control FSM plus datapath registers; results only move when entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (Y != '0) begin
              shift_q <= X;
              dvs_q   <= Y;
              rem_q   <= '0;
              quo_q   <= '0;
              cnt_q   <= CW'(WX - 1);
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end else begin
              // Divide by zero resolves immediately with a saturated quotient.
              q_q     <= '1;
              r_q     <= X[WY-1:0];
              div0_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          shift_q <= shift_q << 1;
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            q_q     <= quo_d;
            r_q     <= rem_d[WY-1:0];
            div0_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign Q    = q_q;
  assign R    = r_q;

endmodule
